// File: rtl/key_debounce.sv
// Multi-channel key conditioner: 2-flop sync, polarity fix, per-channel debounce FSM.
// Press/release accepted 2+DEBOUNCE edges after capture; long pulse LONG_PRESS cycles later; no backpressure.
module key_debounce #(
  parameter int          N          = 4,
  parameter logic [31:0] DEBOUNCE   = 32'd1_000_000,
  parameter logic [31:0] LONG_PRESS = 32'd50_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long
);

  typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE} state_e;

  localparam logic [N-1:0] REL_LVL = {N{ACTIVE_LOW}};

  logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N-1:0] p;
  state_e       state_q [N];
  state_e       state_d [N];
  logic [31:0]  cnt_q [N];
  logic [31:0]  cnt_d [N];
  logic [N-1:0] long_flag_q, long_flag_d;
  logic [N-1:0] key_state_q, key_state_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;
  logic [N-1:0] long_q, long_d;

  // p = 1 means pressed regardless of pin polarity
  assign p = sync2_q ^ REL_LVL;

  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    long_flag_d = long_flag_q;
    key_state_d = key_state_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (p[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = '0;
          end
        end
        DB_PRESS: begin
          if (!p[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == DEBOUNCE - 32'd1) begin
            state_d[i]     = PRESSED;
            cnt_d[i]       = '0;
            key_state_d[i] = 1'b1;
            press_d[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        PRESSED: begin
          if (!p[i]) begin
            state_d[i] = DB_RELEASE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LONG_PRESS - 32'd1) begin
            state_d[i]     = HELD;
            cnt_d[i]       = '0;
            long_flag_d[i] = 1'b1;
            long_d[i]      = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        HELD: begin
          if (!p[i]) begin
            state_d[i] = DB_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        DB_RELEASE: begin
          // A bounce back to pressed restarts the long-press count from zero
          if (p[i]) begin
            state_d[i] = long_flag_q[i] ? HELD : PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEBOUNCE - 32'd1) begin
            state_d[i]     = IDLE;
            cnt_d[i]       = '0;
            key_state_d[i] = 1'b0;
            release_d[i]   = 1'b1;
            long_flag_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + 32'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= REL_LVL;
      sync2_q     <= REL_LVL;
      long_flag_q <= '0;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      long_flag_q <= long_flag_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: active-low and active-high instances against a run-length reference model.
module tb_key_debounce;

  localparam int DB = 4;
  localparam int LP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_lo = 2'b11;
  logic [1:0] key_hi = 2'b00;
  logic [1:0] ks_lo, kp_lo, kr_lo, kl_lo;
  logic [1:0] ks_hi, kp_hi, kr_hi, kl_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_debounce #(.N(2), .DEBOUNCE(32'd4), .LONG_PRESS(32'd10), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(rst_n), .key_in(key_lo),
    .key_state(ks_lo), .key_press(kp_lo), .key_release(kr_lo), .key_long(kl_lo)
  );

  key_debounce #(.N(2), .DEBOUNCE(32'd4), .LONG_PRESS(32'd10), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(rst_n), .key_in(key_hi),
    .key_state(ks_hi), .key_press(kp_hi), .key_release(kr_hi), .key_long(kl_hi)
  );

  // Model index m = dut*2 + channel; dut 0 is active-low, dut 1 active-high.
  // run: consecutive edges the pressed-view disagreed with the accepted level.
  // hold: edges pressed since acceptance or since the last bounce back (-1 after a release-ward edge).
  int run [4];
  int hold [4];
  bit level [4];
  bit fired [4];
  bit pipe1 [4];
  bit pipe2 [4];
  bit m_press [4];
  bit m_rel [4];
  bit m_long [4];
  bit want [4];
  int remain [4];

  function automatic bit pol(input int m);
    return (m < 2);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      run[m] = 0; hold[m] = 0; level[m] = 0; fired[m] = 0;
      pipe1[m] = pol(m); pipe2[m] = pol(m);
      m_press[m] = 0; m_rel[m] = 0; m_long[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 4; m++) begin
      bit pr;
      bit pin;
      pr = pipe2[m] ^ pol(m);
      m_press[m] = 0; m_rel[m] = 0; m_long[m] = 0;
      if (!level[m]) begin
        if (pr) begin
          run[m]++;
          if (run[m] == DB + 1) begin
            level[m] = 1; m_press[m] = 1; run[m] = 0; hold[m] = 0; fired[m] = 0;
          end
        end else run[m] = 0;
      end else begin
        if (!pr) begin
          run[m]++;
          hold[m] = -1;
          if (run[m] == DB + 1) begin
            level[m] = 0; m_rel[m] = 1; run[m] = 0;
          end
        end else begin
          run[m] = 0;
          hold[m]++;
          if (!fired[m] && hold[m] == LP) begin
            fired[m] = 1; m_long[m] = 1;
          end
        end
      end
      pin = (m < 2) ? key_lo[m % 2] : key_hi[m % 2];
      pipe2[m] = pipe1[m];
      pipe1[m] = pin;
    end
  endtask

  task automatic check_one(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] es [2];
    logic [1:0] ep [2];
    logic [1:0] er [2];
    logic [1:0] el [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        es[d][c] = level[d*2+c];
        ep[d][c] = m_press[d*2+c];
        er[d][c] = m_rel[d*2+c];
        el[d][c] = m_long[d*2+c];
      end
    end
    check_one("lo_state",   ks_lo, es[0]);
    check_one("lo_press",   kp_lo, ep[0]);
    check_one("lo_release", kr_lo, er[0]);
    check_one("lo_long",    kl_lo, el[0]);
    check_one("hi_state",   ks_hi, es[1]);
    check_one("hi_press",   kp_hi, ep[1]);
    check_one("hi_release", kr_hi, er[1]);
    check_one("hi_long",    kl_hi, el[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  // pr is the logical pressed pattern, applied to both instances with their own polarity
  task automatic hold_keys(input logic [1:0] pr, input int n);
    key_lo = ~pr;
    key_hi = pr;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;

    // clean press with long press, then release
    hold_keys(2'b01, 30);
    hold_keys(2'b00, 12);
    // glitch rejection, then a press just past the debounce window
    hold_keys(2'b01, 3);
    hold_keys(2'b00, 10);
    hold_keys(2'b01, 6);
    hold_keys(2'b00, 12);
    // release bounce restarting the long-press count
    hold_keys(2'b01, 8);
    hold_keys(2'b00, 2);
    hold_keys(2'b01, 20);
    hold_keys(2'b00, 12);
    // simultaneous channels, release only channel 1
    hold_keys(2'b11, 10);
    hold_keys(2'b01, 10);
    hold_keys(2'b00, 10);

    // asynchronous reset while held, keys kept pressed through deassertion
    hold_keys(2'b11, 25);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) cycle();
    rst_n = 1'b1;
    hold_keys(2'b11, 20);
    hold_keys(2'b00, 12);

    // randomized independent toggling on all four channels
    for (int m = 0; m < 4; m++) begin
      want[m] = 0;
      remain[m] = 0;
    end
    for (int k = 0; k < 800; k++) begin
      for (int m = 0; m < 4; m++) begin
        if (remain[m] == 0) begin
          want[m] = ~want[m];
          remain[m] = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 30) : $urandom_range(1, 8);
        end
        remain[m]--;
      end
      key_lo = {~want[1], ~want[0]};
      key_hi = {want[3], want[2]};
      cycle();
    end
    hold_keys(2'b00, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-channel push-button input conditioner; the input-side counterpart to the LED output drivers on the same board.
- Synchronises N raw key pins and debounces each one independently with a counter-based FSM.
- Emits a debounced level plus single-cycle press, release and long-press pulses.
- Feeds LED pattern controllers and other user-control logic in the single `clk` domain.

Parameters:
- N, 4: number of key channels.
- DEBOUNCE, 32'd1_000_000: cycles a new level must be stable before acceptance. Minimum 2.
- LONG_PRESS, 32'd50_000_000: cycles in the debounced-pressed state before key_long fires. Minimum 2.
- ACTIVE_LOW, 1: 1 means pin low = pressed; 0 means pin high = pressed.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- key_in, input, N: raw asynchronous key pins.
- key_state, output reg, N: debounced level, 1 = pressed.
- key_press, output reg, N: 1-cycle pulse on an accepted press.
- key_release, output reg, N: 1-cycle pulse on an accepted release.
- key_long, output reg, N: 1-cycle pulse when a press has been held LONG_PRESS cycles.

Behaviour:

Reset (reset=0):
- All outputs are 0.
- All FSMs go to IDLE; counters and long flags clear.
- Synchroniser flops load the released level (1 if ACTIVE_LOW, else 0).

Synchroniser and polarity:
- Per channel, a 2-flop synchroniser, then polarity normalisation: p = s2 XOR ACTIVE_LOW, so p=1 means pressed.
- The FSM uses only p.

Per-channel FSM with a 32-bit counter cnt:
- IDLE: if p=1, go to DB_PRESS with cnt=0.
- DB_PRESS:
  - If p=0: go to IDLE, no pulse (glitch rejected).
  - Else if cnt==DEBOUNCE-1: go to PRESSED, cnt=0, key_state<=1, key_press pulse.
  - Else cnt+1.
- PRESSED:
  - If p=0: go to DB_RELEASE, cnt=0.
  - Else if cnt==LONG_PRESS-1: go to HELD, set long flag, key_long pulse.
  - Else cnt+1.
- HELD: if p=0, go to DB_RELEASE, cnt=0.
- DB_RELEASE:
  - If p=1: return to HELD if the long flag is set, else to PRESSED; cnt=0 (long count restarts); no pulse.
  - Else if cnt==DEBOUNCE-1: go to IDLE, key_state<=0, key_release pulse, clear long flag.
  - Else cnt+1.

Latency:
- Pressed level first captured by sync stage 1 at edge t, held stable: key_state rises and key_press asserts after edge t+2+DEBOUNCE.
- Release follows the same rule.
- key_long asserts LONG_PRESS cycles after the edge that entered PRESSED.

Pulse rules:
- Each pulse is exactly 1 cycle, then back to 0.
- key_press and key_release never assert in the same cycle on a channel.
- key_long fires at most once per accepted press.
- Channels are fully independent; simultaneous events on several channels pulse in the same cycle.

Boundary conditions:
- A bounce shorter than DEBOUNCE cycles never changes key_state.
- A bounce during DB_RELEASE does not generate a second key_press.
- Counters never wrap; each is bounded by DEBOUNCE-1 or LONG_PRESS-1.
- Reset asserted mid-operation clears everything immediately, including any in-flight pulse.
- A key held through reset deassertion is treated as a fresh press: full debounce, then key_press.

Test Plan:
(Parameters for all cases unless noted: N=2, DEBOUNCE=4, LONG_PRESS=10, ACTIVE_LOW=1.)
- Clean press: key_in[0] 1→0 captured at edge t and held → key_state[0]=1 and key_press[0]=1 after edge t+6 for 1 cycle; key_long[0] pulses 10 cycles later; key_in[0]→1 → key_release[0] after the same 6-cycle latency, key_state[0]=0.
- Glitch rejection: key_in[0] low for 3 cycles, then high → no pulses, key_state[0] stays 0. Repeat with a low for 6 cycles → key_press[0] fires.
- Release bounce: while pressed, key_in[0] high for 2 cycles, then low → no key_release[0], no second key_press[0]; key_long[0] is still issued, with timing restarted from re-entry to PRESSED.
- Simultaneous channels: key_in=2'b00 at the same edge → key_press=2'b11 in one cycle; release only ch1 → key_release=2'b10, key_state=2'b01.
- Reset mid-press: reset=0 asynchronously during HELD → all outputs 0 with no clock edge required; release reset with the key still low → key_press after the full debounce latency.
- Polarity: ACTIVE_LOW=0, key_in[1] 0→1 held → key_press[1] after 6 cycles.
